// File: rtl/cdb_arbiter_pkg.sv
// Shared processor types for the common data bus: ROB tag, result word and CDB slot entry.
// Also holds the default sizing constants and the reserved "no tag" value.
package cdb_arbiter_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned NUM_CDB = 2;
    localparam int unsigned TAG_W   = 6;
    localparam int unsigned DATA_W  = 32;

    typedef logic [TAG_W-1:0]  RobSize;
    typedef logic [DATA_W-1:0] MemoryWord;

    localparam RobSize CDB_TAG_INVALID = '0;

    typedef struct packed {
        logic      valid;
        RobSize    tag;
        MemoryWord value;
    } cdb_entry;

endpackage

// File: rtl/cdb_arbiter_rr_picker.sv
// Combinational round-robin selector: picks up to NUM_CDB eligible requesters starting at rr_ptr
// and returns one one-hot grant vector per CDB slot plus the index of the last grant.
module rr_picker
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = cdb_arbiter_pkg::NUM_REQ,
    parameter int unsigned NUM_CDB = cdb_arbiter_pkg::NUM_CDB,
    parameter int unsigned PTR_W   = $clog2(NUM_REQ),
    parameter int unsigned CNT_W   = $clog2(NUM_CDB + 1)
) (
    input  logic [NUM_REQ-1:0]              eligible,
    input  logic [PTR_W-1:0]                rr_ptr,
    output logic [NUM_CDB-1:0][NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]                last_idx,
    output logic [CNT_W-1:0]                grant_cnt
);

    int unsigned n;

    // Pass 0 covers rr_ptr..NUM_REQ-1, pass 1 wraps over 0..rr_ptr-1.
    always_comb begin
        grant    = '0;
        last_idx = '0;
        n        = 0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (((pass == 0) == (PTR_W'(i) >= rr_ptr)) && eligible[i] && (n < NUM_CDB)) begin
                    for (int k = 0; k < int'(NUM_CDB); k++) begin
                        if (n == k) begin
                            grant[k][i] = 1'b1;
                        end
                    end
                    last_idx = PTR_W'(i);
                    n        = n + 1;
                end
            end
        end
        grant_cnt = CNT_W'(n);
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing NUM_CDB registered broadcast slots among NUM_REQ result requesters,
// with flush kill, tag-0 protocol flag and a saturating full-utilisation counter.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = cdb_arbiter_pkg::NUM_REQ,
    parameter int unsigned NUM_CDB = cdb_arbiter_pkg::NUM_CDB,
    parameter int unsigned TAG_W   = cdb_arbiter_pkg::TAG_W,
    parameter int unsigned DATA_W  = cdb_arbiter_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]    req_tag,
    input  logic [NUM_REQ*DATA_W-1:0]   req_value,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [NUM_CDB-1:0]          cdb_valid,
    output logic [NUM_CDB*TAG_W-1:0]    cdb_tag,
    output logic [NUM_CDB*DATA_W-1:0]   cdb_value,
    output logic                        proto_err,
    output logic [15:0]                 busy_cycles
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(NUM_CDB + 1);

    logic [NUM_REQ-1:0]              eligible;
    logic [NUM_REQ-1:0]              tag_zero;
    logic [NUM_CDB-1:0][NUM_REQ-1:0] grant;
    logic [PTR_W-1:0]                last_idx;
    logic [CNT_W-1:0]                grant_cnt;

    logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
    logic [NUM_CDB-1:0]        cdb_valid_q, cdb_valid_d;
    logic [NUM_CDB*TAG_W-1:0]  cdb_tag_q, cdb_tag_d;
    logic [NUM_CDB*DATA_W-1:0] cdb_value_q, cdb_value_d;
    logic                      proto_err_q, proto_err_d;
    logic [15:0]               busy_q, busy_d;

    // Holding reset low also masks eligibility so req_ready reads 0 throughout reset.
    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            tag_zero[i] = req_tag[i*TAG_W +: TAG_W] == TAG_W'(CDB_TAG_INVALID);
            eligible[i] = reset && !flush && req_valid[i] && !tag_zero[i];
        end
    end

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .NUM_CDB (NUM_CDB),
        .PTR_W   (PTR_W),
        .CNT_W   (CNT_W)
    ) u_picker (
        .eligible  (eligible),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .last_idx  (last_idx),
        .grant_cnt (grant_cnt)
    );

    always_comb begin
        req_ready   = '0;
        cdb_valid_d = '0;
        cdb_tag_d   = '0;
        cdb_value_d = '0;
        for (int k = 0; k < int'(NUM_CDB); k++) begin
            req_ready      = req_ready | grant[k];
            cdb_valid_d[k] = |grant[k];
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (grant[k][i]) begin
                    cdb_tag_d[k*TAG_W +: TAG_W]    = req_tag[i*TAG_W +: TAG_W];
                    cdb_value_d[k*DATA_W +: DATA_W] = req_value[i*DATA_W +: DATA_W];
                end
            end
        end

        rr_ptr_d = rr_ptr_q;
        if (grant_cnt != '0) begin
            rr_ptr_d = (last_idx == PTR_W'(NUM_REQ - 1)) ? '0 : last_idx + 1'b1;
        end

        proto_err_d = proto_err_q || (|(req_valid & tag_zero));

        busy_d = busy_q;
        if ((grant_cnt == CNT_W'(NUM_CDB)) && (busy_q != 16'hFFFF)) begin
            busy_d = busy_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= '0;
            cdb_tag_q   <= '0;
            cdb_value_q <= '0;
            proto_err_q <= 1'b0;
            busy_q      <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_tag_q   <= cdb_tag_d;
            cdb_value_q <= cdb_value_d;
            proto_err_q <= proto_err_d;
            busy_q      <= busy_d;
        end
    end

    assign cdb_valid   = cdb_valid_q;
    assign cdb_tag     = cdb_tag_q;
    assign cdb_value   = cdb_value_q;
    assign proto_err   = proto_err_q;
    assign busy_cycles = busy_q;

endmodule
